interrupt_sequencer: RTL and testbench



---
 rtl/interrupt_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Arbitrates RES/NMI/IRQ/BRK at instruction boundaries and steps the 7-cycle 6502C entry sequence.
// instDone at n gives FORCE at n+1 and VEC_HI at n+7; RDY low stalls read cycles only, and RES_L low aborts.
module interrupt_sequencer (
  input  logic        phi1,
  input  logic        rst_L,
  input  logic        NMI_L,
  input  logic        IRQ_L,
  input  logic        RES_L,
  input  logic        iFlag,
  input  logic        instDone,
  input  logic        brkOp,
  input  logic        RDY,
  output logic        forceBRK,
  output logic [2:0]  activeInt,
  output logic [2:0]  seqState,
  output logic        pushEn,
  output logic [1:0]  pushSel,
  output logic        nRW,
  output logic        bFlag,
  output logic        vecFetch,
  output logic [15:0] vecAddr,
  output logic        setI,
  output logic        intHandled
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FORCE    = 3'd1,
    DUMMY    = 3'd2,
    PUSH_PCH = 3'd3,
    PUSH_PCL = 3'd4,
    PUSH_P   = 3'd5,
    VEC_LO   = 3'd6,
    VEC_HI   = 3'd7
  } state_t;

  localparam logic [2:0] INT_NONE = 3'd0;
  localparam logic [2:0] INT_RST  = 3'd1;
  localparam logic [2:0] INT_NMI  = 3'd2;
  localparam logic [2:0] INT_IRQ  = 3'd3;
  localparam logic [2:0] INT_BRK  = 3'd4;

  state_t      state, state_nxt;
  logic [2:0]  act_nxt;
  logic        bflag_nxt;
  logic        nmi_prev, nmi_pend, nmi_pend_nxt, nmi_again, nmi_again_nxt;
  logic        nmi_edge, nmi_clr, stall;
  logic        force_nxt, push_en_nxt, nrw_nxt, vec_fetch_nxt, set_i_nxt, handled_nxt;
  logic [1:0]  push_sel_nxt;
  logic [15:0] vec_base, vec_addr_nxt;

  assign nmi_edge = nmi_prev & ~NMI_L;
  assign stall    = ~RDY & nRW & (state != IDLE);
  assign seqState = state;

  always_comb begin
    state_nxt = state;
    act_nxt   = activeInt;
    bflag_nxt = bFlag;
    if (!RES_L) begin
      state_nxt = IDLE;
      act_nxt   = INT_RST;
      bflag_nxt = 1'b0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (activeInt == INT_RST) begin
            state_nxt = FORCE;
          end else if (instDone) begin
            if (nmi_pend) begin
              state_nxt = FORCE;
              act_nxt   = INT_NMI;
            end else if (~IRQ_L & ~iFlag) begin
              state_nxt = FORCE;
              act_nxt   = INT_IRQ;
            end else if (brkOp) begin
              state_nxt = FORCE;
              act_nxt   = INT_BRK;
              bflag_nxt = 1'b1;
            end
          end
        end
        FORCE:    state_nxt = DUMMY;
        DUMMY:    state_nxt = PUSH_PCH;
        PUSH_PCH: state_nxt = PUSH_PCL;
        PUSH_PCL: state_nxt = PUSH_P;
        PUSH_P: begin
          state_nxt = VEC_LO;
          // NMI hijacks IRQ/BRK after P is pushed; the pushed B bit stays as is
          if (((activeInt == INT_IRQ) || (activeInt == INT_BRK)) && nmi_pend)
            act_nxt = INT_NMI;
        end
        VEC_LO:   state_nxt = VEC_HI;
        VEC_HI: begin
          state_nxt = IDLE;
          act_nxt   = INT_NONE;
          bflag_nxt = 1'b0;
        end
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Edges seen during an NMI's own sequence survive the clear at VEC_LO entry
  always_comb begin
    nmi_clr       = (state == PUSH_P) && (state_nxt == VEC_LO) && (act_nxt == INT_NMI);
    nmi_pend_nxt  = nmi_edge | (nmi_clr ? nmi_again : nmi_pend);
    nmi_again_nxt = (state_nxt == IDLE) ? 1'b0
                  : (nmi_again | (nmi_edge & (act_nxt == INT_NMI)));
  end

  always_comb begin
    force_nxt     = 1'b0;
    push_en_nxt   = 1'b0;
    push_sel_nxt  = 2'd0;
    nrw_nxt       = 1'b1;
    vec_fetch_nxt = 1'b0;
    vec_addr_nxt  = 16'h0000;
    vec_base      = 16'hFFFE;
    if (act_nxt == INT_RST)      vec_base = 16'hFFFC;
    else if (act_nxt == INT_NMI) vec_base = 16'hFFFA;
    case (state_nxt)
      FORCE:    force_nxt = (act_nxt != INT_BRK);
      PUSH_PCH: begin
        push_en_nxt  = 1'b1;
        push_sel_nxt = 2'd0;
        nrw_nxt      = (act_nxt == INT_RST);
      end
      PUSH_PCL: begin
        push_en_nxt  = 1'b1;
        push_sel_nxt = 2'd1;
        nrw_nxt      = (act_nxt == INT_RST);
      end
      PUSH_P: begin
        push_en_nxt  = 1'b1;
        push_sel_nxt = 2'd2;
        nrw_nxt      = (act_nxt == INT_RST);
      end
      VEC_LO: begin
        vec_fetch_nxt = 1'b1;
        vec_addr_nxt  = vec_base;
      end
      VEC_HI: begin
        vec_fetch_nxt = 1'b1;
        vec_addr_nxt  = vec_base + 16'd1;
      end
      default: ;
    endcase
    // Pulses fire only on state entry so a RDY stall never repeats them
    set_i_nxt   = (state_nxt == VEC_LO) && (state != VEC_LO);
    handled_nxt = (state_nxt == VEC_HI) && (state != VEC_HI);
  end

  always_ff @(posedge phi1 or negedge rst_L) begin
    if (!rst_L) begin
      state      <= IDLE;
      activeInt  <= INT_NONE;
      bFlag      <= 1'b0;
      forceBRK   <= 1'b0;
      pushEn     <= 1'b0;
      pushSel    <= 2'd0;
      nRW        <= 1'b1;
      vecFetch   <= 1'b0;
      vecAddr    <= 16'h0000;
      setI       <= 1'b0;
      intHandled <= 1'b0;
      nmi_prev   <= 1'b1;
      nmi_pend   <= 1'b0;
      nmi_again  <= 1'b0;
    end else begin
      state      <= state_nxt;
      activeInt  <= act_nxt;
      bFlag      <= bflag_nxt;
      forceBRK   <= force_nxt;
      pushEn     <= push_en_nxt;
      pushSel    <= push_sel_nxt;
      nRW        <= nrw_nxt;
      vecFetch   <= vec_fetch_nxt;
      vecAddr    <= vec_addr_nxt;
      setI       <= set_i_nxt;
      intHandled <= handled_nxt;
      nmi_prev   <= NMI_L;
      nmi_pend   <= nmi_pend_nxt;
      nmi_again  <= nmi_again_nxt;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: step-count model checked every cycle plus literal spot checks.
module tb_interrupt_sequencer;

  logic        phi1 = 1'b0;
  logic        rst_L = 1'b0;
  logic        NMI_L = 1'b1, IRQ_L = 1'b1, RES_L = 1'b1, iFlag = 1'b1;
  logic        instDone = 1'b0, brkOp = 1'b0, RDY = 1'b1;
  logic        forceBRK, pushEn, nRW, bFlag, vecFetch, setI, intHandled;
  logic [2:0]  activeInt, seqState;
  logic [1:0]  pushSel;
  logic [15:0] vecAddr;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 phi1 = ~phi1;

  interrupt_sequencer dut (
    .phi1(phi1), .rst_L(rst_L), .NMI_L(NMI_L), .IRQ_L(IRQ_L), .RES_L(RES_L),
    .iFlag(iFlag), .instDone(instDone), .brkOp(brkOp), .RDY(RDY),
    .forceBRK(forceBRK), .activeInt(activeInt), .seqState(seqState),
    .pushEn(pushEn), .pushSel(pushSel), .nRW(nRW), .bFlag(bFlag),
    .vecFetch(vecFetch), .vecAddr(vecAddr), .setI(setI), .intHandled(intHandled)
  );

  // Model: sequence position 0..7, source code, and NMI edges counted against those already serviced
  int m_step = 0, m_act = 0, e_cnt = 0, mark = 0, sel_cnt = 0;
  bit m_brk = 1'b0, m_new = 1'b0, m_prev = 1'b1;

  function automatic int m_base(input int a);
    return (a == 1) ? 'hFFFC : (a == 2) ? 'hFFFA : 'hFFFE;
  endfunction
  function automatic bit m_pushing();
    return (m_step >= 3) && (m_step <= 5);
  endfunction
  function automatic bit m_nrw();
    return !(m_pushing() && (m_act != 1));
  endfunction

  always @(posedge phi1 or negedge rst_L) begin
    if (!rst_L) begin
      m_step = 0; m_act = 0; m_brk = 1'b0; m_new = 1'b0; m_prev = 1'b1;
      e_cnt = 0; mark = 0; sel_cnt = 0;
    end else begin : upd
      int old;
      bit edge_s, pend, stall;
      old    = m_step;
      edge_s = m_prev && !NMI_L;
      pend   = e_cnt > mark;
      stall  = (m_step != 0) && !RDY && m_nrw();
      if (!RES_L) begin
        m_step = 0; m_act = 1; m_brk = 1'b0;
      end else if (!stall) begin
        if (m_step == 0) begin
          if (m_act == 1) m_step = 1;
          else if (instDone) begin
            if (pend) begin m_act = 2; sel_cnt = e_cnt; m_step = 1; end
            else if (!IRQ_L && !iFlag) begin m_act = 3; m_step = 1; end
            else if (brkOp) begin m_act = 4; m_brk = 1'b1; m_step = 1; end
          end
        end else if (m_step == 7) begin
          m_step = 0; m_act = 0; m_brk = 1'b0;
        end else begin
          if (m_step == 5) begin
            if ((m_act == 3 || m_act == 4) && pend) begin m_act = 2; mark = e_cnt; end
            else if (m_act == 2) mark = sel_cnt;
          end
          m_step = m_step + 1;
        end
      end
      m_new = (m_step != old);
      if (edge_s) e_cnt = e_cnt + 1;
      m_prev = NMI_L;
    end
  end

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge phi1) begin
    if (cmp_en) begin
      chk("seqState", int'(seqState), m_step);
      chk("activeInt", int'(activeInt), m_act);
      chk("forceBRK", int'(forceBRK), int'(m_step == 1 && m_act != 4));
      chk("pushEn", int'(pushEn), int'(m_pushing()));
      chk("pushSel", int'(pushSel), m_pushing() ? m_step - 3 : 0);
      chk("nRW", int'(nRW), int'(m_nrw()));
      chk("bFlag", int'(bFlag), int'(m_brk));
      chk("vecFetch", int'(vecFetch), int'(m_step >= 6));
      chk("vecAddr", int'(vecAddr), (m_step >= 6) ? m_base(m_act) + m_step - 6 : 0);
      chk("setI", int'(setI), int'(m_step == 6 && m_new));
      chk("intHandled", int'(intHandled), int'(m_step == 7 && m_new));
    end
  end

  task automatic tick();
    @(posedge phi1);
    #2;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic boundary();
    instDone = 1'b1;
    tick();
    instDone = 1'b0;
    brkOp = 1'b0;
  endtask

  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst seqState", int'(seqState), 0);
    chk("rst activeInt", int'(activeInt), 0);
    chk("rst nRW", int'(nRW), 1);
    chk("rst vecAddr", int'(vecAddr), 0);
    chk("rst strobes", int'({forceBRK, pushEn, vecFetch, setI, intHandled, bFlag}), 0);
    rst_L = 1'b1;
    ticks(2);

    // IRQ with I clear; a stray instDone in FORCE is ignored
    IRQ_L = 1'b0; iFlag = 1'b0;
    boundary();
    IRQ_L = 1'b1;
    chk("irq FORCE", int'(seqState), 1);
    chk("irq forceBRK", int'(forceBRK), 1);
    chk("irq activeInt", int'(activeInt), 3);
    boundary();
    tick();
    chk("irq PCH write", int'({pushSel, nRW, bFlag}), 0);
    ticks(2);
    chk("irq P sel", int'(pushSel), 2);
    tick();
    chk("irq vec lo", int'(vecAddr), 'hFFFE);
    chk("irq setI", int'(setI), 1);
    tick();
    chk("irq vec hi", int'(vecAddr), 'hFFFF);
    chk("irq handled", int'(intHandled), 1);
    tick();
    chk("irq done act", int'(activeInt), 0);

    // IRQ masked by I
    IRQ_L = 1'b0; iFlag = 1'b1;
    boundary();
    chk("irq masked", int'(seqState), 0);
    IRQ_L = 1'b1; iFlag = 1'b0;
    tick();

    // BRK hijacked by an NMI edge during PUSH_PCL
    brkOp = 1'b1;
    boundary();
    chk("brk forceBRK", int'(forceBRK), 0);
    chk("brk activeInt", int'(activeInt), 4);
    ticks(3);
    NMI_L = 1'b0;
    tick();
    chk("brk P bFlag", int'(bFlag), 1);
    tick();
    chk("hijack act", int'(activeInt), 2);
    chk("hijack vec lo", int'(vecAddr), 'hFFFA);
    chk("hijack bFlag", int'(bFlag), 1);
    tick();
    chk("hijack vec hi", int'(vecAddr), 'hFFFB);
    tick();
    boundary();
    chk("hijack nmi cleared", int'(seqState), 0);
    NMI_L = 1'b1;
    tick();

    // RES abort during an IRQ's PUSH_PCH, then reset sequence
    IRQ_L = 1'b0;
    boundary();
    IRQ_L = 1'b1;
    ticks(2);
    RES_L = 1'b0;
    tick();
    chk("res abort state", int'(seqState), 0);
    chk("res abort act", int'(activeInt), 1);
    chk("res abort strobes", int'({pushEn, vecFetch, forceBRK}), 0);
    ticks(2);
    RES_L = 1'b1;
    tick();
    chk("rst FORCE", int'({seqState, activeInt}), {3'd1, 3'd1});
    ticks(2);
    chk("rst push read", int'({pushEn, nRW}), 3);
    ticks(3);
    chk("rst vec lo", int'(vecAddr), 'hFFFC);
    tick();
    chk("rst vec hi", int'(vecAddr), 'hFFFD);
    tick();

    // NMI held low: once; re-edge inside its own sequence is kept
    NMI_L = 1'b0;
    tick();
    boundary();
    chk("nmi1 act", int'(activeInt), 2);
    ticks(7);
    boundary();
    chk("nmi held once", int'(seqState), 0);
    NMI_L = 1'b1; tick();
    NMI_L = 1'b0; tick();
    boundary();
    chk("nmi2 act", int'(activeInt), 2);
    NMI_L = 1'b1; tick();
    NMI_L = 1'b0; tick();
    ticks(5);
    chk("nmi2 done", int'(seqState), 0);
    boundary();
    chk("nmi3 kept", int'(activeInt), 2);
    ticks(7);
    NMI_L = 1'b1;
    tick();

    // RDY stall in VEC_LO, no stall in PUSH_P
    IRQ_L = 1'b0;
    boundary();
    IRQ_L = 1'b1;
    ticks(5);
    chk("stall setI", int'(setI), 1);
    RDY = 1'b0;
    ticks(3);
    chk("stall hold", int'(seqState), 6);
    chk("stall no repeat", int'(setI), 0);
    RDY = 1'b1;
    tick();
    chk("stall release", int'({seqState, intHandled}), {3'd7, 1'b1});
    tick();
    brkOp = 1'b1;
    boundary();
    ticks(4);
    RDY = 1'b0;
    tick();
    chk("write ignores RDY", int'(seqState), 6);
    RDY = 1'b1;
    ticks(2);

    // Simultaneous RES, NMI edge and IRQ
    RES_L = 1'b0; NMI_L = 1'b0; IRQ_L = 1'b0; iFlag = 1'b0;
    boundary();
    chk("simul res wins", int'({seqState, activeInt}), {3'd0, 3'd1});
    RES_L = 1'b1;
    tick();
    chk("simul rst runs", int'(activeInt), 1);
    ticks(7);
    chk("simul rst done", int'(activeInt), 0);
    boundary();
    chk("simul nmi next", int'(activeInt), 2);
    ticks(7);
    IRQ_L = 1'b1; NMI_L = 1'b1; iFlag = 1'b1;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
